// File: rtl/pwm_drive_pkg.sv
// Shared types and helpers for the multi-channel PWM drive controller.
package pwm_drive_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_t;

  // Channel-select width; a single-channel build still carries a 1-bit select.
  function automatic int unsigned ch_sel_w(input int unsigned n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/pwm_drive_channel.sv
// One drive channel: duty/dir/remaining registers, countdown and registered PWM.
module pwm_drive_channel
  import pwm_drive_pkg::*;
#(
  parameter int unsigned PWM_W = 7,
  parameter int unsigned DUR_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             tick_i,
  input  logic [PWM_W-1:0] pwm_cnt_i,
  input  logic             load_i,
  input  logic             dir_i,
  input  logic [PWM_W-1:0] duty_i,
  input  logic [DUR_W-1:0] dur_i,
  input  logic             estop_i,
  output logic             pwm_o,
  output logic             dir_o,
  output logic             busy_o,
  output logic             done_o
);

  ch_state_t        state_q, state_d;
  logic [PWM_W-1:0] duty_q, duty_d;
  logic             dir_q, dir_d;
  logic [DUR_W-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             pwm_q, pwm_d;
  logic             dir_out_q;

  // Next state: estop beats a load, a load beats an expiry on the same edge.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    if (estop_i) begin
      state_d = IDLE;
    end else if (load_i) begin
      if (dur_i != '0) begin
        state_d = RUN;
        duty_d  = duty_i;
        dir_d   = dir_i;
        rem_d   = dur_i;
      end else begin
        state_d = IDLE;
        duty_d  = '0;
      end
    end else if ((state_q == RUN) && tick_i) begin
      rem_d = rem_q - 1'b1;
      if (rem_q == DUR_W'(1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
    pwm_d = (state_q == RUN) && (pwm_cnt_i < duty_q);
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      duty_q    <= '0;
      dir_q     <= 1'b0;
      rem_q     <= '0;
      done_q    <= 1'b0;
      pwm_q     <= 1'b0;
      dir_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      duty_q    <= duty_d;
      dir_q     <= dir_d;
      rem_q     <= rem_d;
      done_q    <= done_d;
      pwm_q     <= pwm_d;
      dir_out_q <= dir_q;
    end
  end

  assign pwm_o  = pwm_q;
  assign dir_o  = dir_out_q;
  assign busy_o = (state_q == RUN);
  assign done_o = done_q;

endmodule

// File: rtl/pwm_drive_ctrl.sv
// Multi-channel PWM drive controller: shared PWM counter and tick prescaler,
// command address decode, and one pwm_drive_channel per output.
module pwm_drive_ctrl
  import pwm_drive_pkg::*;
#(
  parameter  int unsigned N_CH     = 2,
  parameter  int unsigned PWM_W    = 7,
  parameter  int unsigned DUR_W    = 8,
  parameter  int unsigned TICK_DIV = 1000,
  localparam int unsigned CH_W     = ch_sel_w(N_CH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CH_W-1:0]  cmd_ch,
  input  logic             cmd_dir,
  input  logic [PWM_W-1:0] cmd_duty,
  input  logic [DUR_W-1:0] cmd_dur,
  input  logic             estop,
  output logic [N_CH-1:0]  pwm_out,
  output logic [N_CH-1:0]  dir_out,
  output logic [N_CH-1:0]  busy,
  output logic [N_CH-1:0]  done,
  output logic             cmd_err
);

  localparam int unsigned PS_W = $clog2(TICK_DIV);

  typedef struct packed {
    logic             dir;
    logic [PWM_W-1:0] duty;
    logic [DUR_W-1:0] dur;
  } drive_cmd_t;

  drive_cmd_t       cmd;
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PS_W-1:0]  presc_q, presc_d;
  logic             tick;
  logic             accept;
  logic             ch_ok;
  logic             cmd_err_q, cmd_err_d;
  logic [N_CH-1:0]  load;

  assign cmd       = '{dir: cmd_dir, duty: cmd_duty, dur: cmd_dur};
  assign cmd_ready = ~reset & ~estop;
  assign accept    = cmd_valid & cmd_ready;
  assign ch_ok     = 32'(cmd_ch) < N_CH;
  assign tick      = (presc_q == PS_W'(TICK_DIV - 1));

  // Free-running counters; the prescaler phase is independent of commands.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    presc_d   = tick ? '0 : presc_q + 1'b1;
    cmd_err_d = accept & ~ch_ok;
  end

  // Shared counter and error-pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt_q <= '0;
      presc_q   <= '0;
      cmd_err_q <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      presc_q   <= presc_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  assign cmd_err = cmd_err_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign load[g] = accept & (cmd_ch == CH_W'(g));

    pwm_drive_channel #(
      .PWM_W (PWM_W),
      .DUR_W (DUR_W)
    ) u_ch (
      .clk_i     (clk),
      .reset_i   (reset),
      .tick_i    (tick),
      .pwm_cnt_i (pwm_cnt_q),
      .load_i    (load[g]),
      .dir_i     (cmd.dir),
      .duty_i    (cmd.duty),
      .dur_i     (cmd.dur),
      .estop_i   (estop),
      .pwm_o     (pwm_out[g]),
      .dir_o     (dir_out[g]),
      .busy_o    (busy[g]),
      .done_o    (done[g])
    );
  end

endmodule
